// File: rtl/frog_loader.sv
// rtl/frog_loader.sv - host-side serial load/gap/test sequencer for frog_chip
// Optional signature capture is enabled by defining FROG_LOADER_SIG_EN; prog drives the frog_chip program pin.
module frog_loader #(
  parameter int N      = 16,
  parameter int GAP    = 5,
  parameter int TEST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      program_word,
  input  logic [N-1:0]      seed_word,
  input  logic [TEST_W-1:0] test_cycles,
  output logic              busy,
  output logic              done,
  output logic              load,
  output logic              prog,
  output logic              seed,
  output logic              test
`ifdef FROG_LOADER_SIG_EN
  ,
  input  logic              dut_out,
  output logic [N-1:0]      signature
`endif
);

  localparam int CW = $clog2(((N > GAP) ? N : GAP) + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_TEST  = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      prog_sr;
  logic [N-1:0]      seed_sr;
  logic [TEST_W-1:0] test_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      prog_sr  <= '0;
      seed_sr  <= '0;
      test_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load     <= 1'b0;
      prog     <= 1'b0;
      seed     <= 1'b0;
      test     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // bit 0 goes out on the accepting edge; the remainder is queued in the shift regs
            state    <= S_SHIFT;
            busy     <= 1'b1;
            load     <= 1'b1;
            prog     <= program_word[0];
            seed     <= seed_word[0];
            prog_sr  <= program_word >> 1;
            seed_sr  <= seed_word >> 1;
            test_cnt <= test_cycles;
            cnt      <= '0;
          end
        end
        S_SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            state <= S_GAP;
            load  <= 1'b0;
            prog  <= 1'b0;
            seed  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt     <= cnt + CW'(1);
            prog    <= prog_sr[0];
            seed    <= seed_sr[0];
            prog_sr <= prog_sr >> 1;
            seed_sr <= seed_sr >> 1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (test_cnt == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_TEST;
              test  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_TEST: begin
          // test_cnt holds the remaining high cycles including the current one
          if (test_cnt == TEST_W'(1)) begin
            state <= S_IDLE;
            test  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            test_cnt <= test_cnt - TEST_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FROG_LOADER_SIG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= '0;
    end else if (state == S_IDLE && start) begin
      signature <= '0;
    end else if (test) begin
      signature <= {signature[N-2:0], dut_out};
    end
  end
`endif

endmodule
